// File: rtl/dcache_pkg.sv
// Shared encodings and types for the L1 data cache: load/store funct3 codes,
// miss FSM states and line geometry.
package dcache_pkg;

  localparam int unsigned LINE_BITS = 128;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    UPDATE
  } state_e;

endpackage

// File: rtl/dcache_load_align.sv
// Picks the addressed word/half/byte out of a cache line and sign- or
// zero-extends it according to the load funct3. Purely combinational.
module dcache_load_align
  import dcache_pkg::*;
(
  input  logic                 en_i,
  input  logic [LINE_BITS-1:0] line_i,
  input  logic [3:0]           offset_i,
  input  logic [2:0]           funct3_i,
  output logic [31:0]          data_o
);

  logic [31:0] word;
  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    word     = line_i[{offset_i[3:2], 5'd0} +: 32];
    half     = word[{offset_i[1], 4'd0} +: 16];
    byte_sel = word[{offset_i[1:0], 3'd0} +: 8];
    data_o   = '0;
    if (en_i) begin
      unique case (funct3_i)
        LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
        LD_LH:   data_o = {{16{half[15]}}, half};
        LD_LW:   data_o = word;
        LD_LBU:  data_o = {24'd0, byte_sel};
        LD_LHU:  data_o = {16'd0, half};
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache. Hits finish in the
// request cycle; misses walk WRITEBACK/ALLOCATE/UPDATE with whole 16-byte lines.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          DMEM_ADDR,
  input  logic [31:0]          DMEM_DATA_WRITE,
  input  logic [3:0]           DMEM_READ,
  input  logic [2:0]           DMEM_WRITE,
  output logic [31:0]          DMEM_DATA_READ,
  output logic                 BUSYWAIT,
  output logic                 MEM_READ,
  output logic                 MEM_WRITE,
  output logic [27:0]          MEM_ADDR,
  output logic [LINE_BITS-1:0] MEM_WRITEDATA,
  input  logic [LINE_BITS-1:0] MEM_READDATA,
  input  logic                 MEM_BUSYWAIT
);

  localparam int unsigned TagBits  = 32 - INDEX_BITS - 4;
  localparam int unsigned NumLines = 1 << INDEX_BITS;

  logic [TagBits-1:0]    tag;
  logic [INDEX_BITS-1:0] idx;
  logic                  req;
  logic                  hit;
  logic                  load_en;

  state_e state_q, state_d;
  logic   mem_read_q, mem_read_d;
  logic   mem_write_q, mem_write_d;

  logic [LINE_BITS-1:0] data_q  [NumLines];
  logic [LINE_BITS-1:0] data_d  [NumLines];
  logic [TagBits-1:0]   tag_q   [NumLines];
  logic [TagBits-1:0]   tag_d   [NumLines];
  logic [NumLines-1:0]  valid_q, valid_d;
  logic [NumLines-1:0]  dirty_q, dirty_d;

  logic [LINE_BITS-1:0] cur_line;
  logic [LINE_BITS-1:0] merged_line;
  logic [31:0]          cur_word;
  logic [31:0]          new_word;

  assign tag = DMEM_ADDR[31 -: TagBits];
  assign idx = DMEM_ADDR[INDEX_BITS+3:4];
  assign req = DMEM_READ[3] | DMEM_WRITE[2];
  assign hit = valid_q[idx] & (tag_q[idx] == tag);

  // Store data merged into the addressed line; only committed on an IDLE hit.
  always_comb begin
    cur_line = data_q[idx];
    cur_word = cur_line[{DMEM_ADDR[3:2], 5'd0} +: 32];
    new_word = cur_word;
    unique case (DMEM_WRITE[1:0])
      ST_SB:   new_word[{DMEM_ADDR[1:0], 3'd0} +: 8] = DMEM_DATA_WRITE[7:0];
      ST_SH:   new_word[{DMEM_ADDR[1], 4'd0} +: 16]  = DMEM_DATA_WRITE[15:0];
      ST_SW:   new_word = DMEM_DATA_WRITE;
      default: new_word = cur_word;
    endcase
    merged_line = cur_line;
    merged_line[{DMEM_ADDR[3:2], 5'd0} +: 32] = new_word;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (!MEM_BUSYWAIT) state_d = ALLOCATE;
      ALLOCATE:  if (!MEM_BUSYWAIT) state_d = UPDATE;
      UPDATE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    mem_read_d  = (state_d == ALLOCATE);
    mem_write_d = (state_d == WRITEBACK);
  end

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (state_q == UPDATE) begin
      data_d[idx]  = MEM_READDATA;
      tag_d[idx]   = tag;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (state_q == IDLE && hit && DMEM_WRITE[2]) begin
      data_d[idx]  = merged_line;
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Data and tag storage are left uninitialised by reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  always_comb begin
    BUSYWAIT      = !RST && ((state_q != IDLE) || (req && !hit));
    MEM_READ      = mem_read_q;
    MEM_WRITE     = mem_write_q;
    MEM_ADDR      = '0;
    MEM_WRITEDATA = '0;
    unique case (state_q)
      WRITEBACK: begin
        MEM_ADDR      = {tag_q[idx], idx};
        MEM_WRITEDATA = data_q[idx];
      end
      ALLOCATE, UPDATE: MEM_ADDR = DMEM_ADDR[31:4];
      default: MEM_ADDR = '0;
    endcase
    load_en = !RST && (state_q == IDLE) && hit && DMEM_READ[3];
  end

  dcache_load_align u_load_align (
    .en_i     (load_en),
    .line_i   (data_q[idx]),
    .offset_i (DMEM_ADDR[3:0]),
    .funct3_i (DMEM_READ[2:0]),
    .data_o   (DMEM_DATA_READ)
  );

endmodule
